cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
Bus-and-register datapath of the 8-bit SAP CPU, directly downstream of the microcode decoder. It consumes the decoder's control strobes and contains the shared 8-bit bus, PC, MAR, 16x8 RAM, IR, A, B, ALU, flags and output register. The IR value is returned to the decoder as `insn`. A programming port loads RAM while `prog_mode` is high.

Parameters:
- DATA_W, 8, bus/register width. The design is fixed at 8; the parameter is for documentation only.
- ADDR_W, 4, PC/MAR width. RAM depth is 2**ADDR_W = 16.

Ports:
- clk  in  1  system clock. All state updates on posedge; the decoder changes strobes on negedge.
- rst  in  1  reset, asynchronous, active-low.
- hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j  in  1 each  decoder control strobes.
- prog_mode  in  1  programming mode.
- prog_we  in  1  RAM write strobe, honoured only in prog_mode.
- prog_addr  in  4  programming address.
- prog_data  in  8  programming data.
- insn  out  8  IR contents, to the decoder.
- out_val  out  8  output register.
- out_valid  out  1  one-cycle pulse after the output register loads.
- pc  out  4  program counter.
- bus  out  8  current bus value, for debug.
- bus_conflict  out  1  more than one bus driver is enabled.
- cf  out  1  carry flag.
- zf  out  1  zero flag.

Behaviour:
- Bus (combinational) is driven by the first enabled source, in this priority order:
  - ro → RAM[MAR]
  - io → {4'h0, IR[3:0]}
  - ao → A
  - sumo → alu_res
  - co → {4'h0, PC}
  - no driver → 8'h00
- bus_conflict = 1 when two or more of ro, io, ao, sumo, co are high (combinational).
- ALU (combinational): alu9 = {1'b0,A} + {1'b0, sub ? ~B : B} + sub.
  - alu_res = alu9[7:0]; carry = alu9[8].
  - For subtraction, carry = 1 means no borrow (A >= B).
- Posedge updates occur only when rst=1, hlt=0 and prog_mode=0. Every register not named holds its value.
  - mi: MAR <= bus[3:0].
  - ri: RAM[MAR] <= bus, using the MAR value from before this edge. If ri and ro are both high, no write occurs.
  - ii: IR <= bus.
  - ai: A <= bus. If sumo is also high, cf <= carry and zf <= (alu_res==0). The flags change at no other time.
  - bi: B <= bus.
  - oi: out_val <= bus; out_valid <= 1 for exactly one cycle. Otherwise out_valid <= 0.
  - j: PC <= bus[3:0]. j takes priority over ce.
  - ce (with no j): PC <= PC+1, wrapping 4'hF → 4'h0.
- Same-edge read/write: every register load uses the bus value from before the edge. Example: ai with ao reloads A with its own value; ce with co puts the old PC on the bus.
- hlt=1 freezes all CPU registers and RAM; out_valid is forced to 0. Once hlt is seen, only rst clears it, because hlt is a decoder output.
- prog_mode=1:
  - CPU registers hold.
  - prog_we=1 writes RAM[prog_addr] <= prog_data on posedge. Control strobes are ignored.
  - Leaving prog_mode needs no special handling; the system asserts rst to restart execution.
- Reset (rst=0, asynchronous) clears PC, MAR, IR, A, B, out_val, cf, zf and out_valid to 0.
  - RAM is not reset, so its contents survive reset and reset mid-instruction.
  - Reset asserted mid-cycle takes effect immediately; a RAM write on that edge is suppressed.
- RAM is 16x8 and may be an inferred register array; its contents after power-up are don't-care.

Test Plan:
- Reset with RAM preloaded → PC=0, MAR=0, A=B=IR=0, cf=zf=0, out_valid=0; RAM[3]=8'h2A is unchanged after rst pulses.
- Programming: prog_mode=1, write 8'h1E@0 and 8'h07@14 → RAM reads back the same values. Strobes ai/ce pulsed during programming leave A=0 and PC=0.
- LDA 14, driven through the sequence co+mi, ro+ii+ce, io+mi, ro+ai → MAR=0, IR=8'h1E, PC=1, MAR=14, A=8'h07, insn=8'h1E.
- ALU and flags:
  - A=8'hF0, B=8'h20, sumo+ai → A=8'h10, cf=1, zf=0.
  - A=5, B=5, sub+sumo+ai → A=0, cf=1, zf=1.
  - A=3, B=5, sub → A=8'hFE, cf=0.
- PC and output:
  - PC=15, ce → PC=0.
  - Bus=8'h09 via io with j+ce → PC=9.
  - ao+oi with A=8'h42 → out_val=8'h42; out_valid high for exactly one cycle.
- Conflict and halt:
  - ro+ao together → bus=RAM[MAR], bus_conflict=1.
  - hlt=1 with ai/ce/ri pulsed → no register or RAM change.
  - rst → registers cleared.

Source files
------------

// File: rtl/cpu_datapath.sv
// Bus-and-register datapath of the 8-bit SAP CPU.
//
// Sits downstream of the microcode decoder and turns its control strobes into
// register transfers over a single shared bus. Holds PC, MAR, a 16x8 RAM, IR,
// A, B, the ALU, the carry/zero flags and the output register. A programming
// port loads RAM while prog_mode is high.
//
// Ports:
//   clk, rst           clock (posedge state updates), async active-low reset
//   hlt .. j           decoder control strobes (one bit each)
//   prog_mode          programming mode: CPU state holds, RAM writable via port
//   prog_we/addr/data  programming write port
//   insn               IR contents, back to the decoder
//   out_val/out_valid  output register and its one-cycle load pulse
//   pc                 program counter
//   bus, bus_conflict  debug view of the bus and a multi-driver indication
//   cf, zf             carry and zero flags
module cpu_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              mi,
  input  logic              ri,
  input  logic              ro,
  input  logic              io,
  input  logic              ii,
  input  logic              ai,
  input  logic              ao,
  input  logic              sumo,
  input  logic              sub,
  input  logic              bi,
  input  logic              oi,
  input  logic              ce,
  input  logic              co,
  input  logic              j,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] insn,
  output logic [DATA_W-1:0] out_val,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus,
  output logic              bus_conflict,
  output logic              cf,
  output logic              zf
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;
  logic              cf_q;
  logic              zf_q;
  logic [DATA_W-1:0] ram_q [Depth];

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   alu9;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [2:0]        n_drv;
  logic              run;

  // Subtraction is A + ~B + 1, so carry=1 means no borrow.
  always_comb begin
    b_op      = sub ? ~b_q : b_q;
    alu9      = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
    alu_res   = alu9[DATA_W-1:0];
    alu_carry = alu9[DATA_W];
  end

  // Priority bus mux; lower-priority drivers are simply shadowed.
  always_comb begin
    bus = '0;
    if (ro)        bus = ram_q[mar_q];
    else if (io)   bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    else if (ao)   bus = a_q;
    else if (sumo) bus = alu_res;
    else if (co)   bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
  end

  always_comb begin
    n_drv        = {2'b0, ro} + {2'b0, io} + {2'b0, ao} + {2'b0, sumo} + {2'b0, co};
    bus_conflict = (n_drv > 3'd1);
  end

  assign run = ~hlt & ~prog_mode;

  // All loads sample the pre-edge bus, so same-edge read/modify works.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
    end else if (run) begin
      if (mi) mar_q <= bus[ADDR_W-1:0];
      if (ii) ir_q <= bus;
      if (ai) begin
        a_q <= bus;
        if (sumo) begin
          cf_q <= alu_carry;
          zf_q <= (alu_res == '0);
        end
      end
      if (bi) b_q <= bus;
      if (oi) out_q <= bus;
      out_valid_q <= oi;
      if (j)       pc_q <= bus[ADDR_W-1:0];
      else if (ce) pc_q <= pc_q + ADDR_W'(1);
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  // RAM has no reset; sampling rst here drops a write on an edge where reset
  // is already asserted. A RAM-to-RAM transfer (ri with ro) is not a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (prog_mode) begin
        if (prog_we) ram_q[prog_addr] <= prog_data;
      end else if (!hlt && ri && !ro) begin
        ram_q[mar_q] <= bus;
      end
    end
  end

  assign insn      = ir_q;
  assign out_val   = out_q;
  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign cf        = cf_q;
  assign zf        = zf_q;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

  localparam int HLT = 0, MI = 1, RI = 2, RO = 3, IO = 4, II = 5, AI = 6, AO = 7;
  localparam int SUMO = 8, SUB = 9, BI = 10, OI = 11, CE = 12, CO = 13, J = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [14:0] s_v = '0;
  logic       prog_mode = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] insn, out_val, bus;
  logic       out_valid, bus_conflict, cf, zf;
  logic [3:0] pc;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .rst(rst),
    .hlt(s_v[HLT]), .mi(s_v[MI]), .ri(s_v[RI]), .ro(s_v[RO]), .io(s_v[IO]),
    .ii(s_v[II]), .ai(s_v[AI]), .ao(s_v[AO]), .sumo(s_v[SUMO]), .sub(s_v[SUB]),
    .bi(s_v[BI]), .oi(s_v[OI]), .ce(s_v[CE]), .co(s_v[CO]), .j(s_v[J]),
    .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .insn(insn), .out_val(out_val), .out_valid(out_valid),
    .pc(pc), .bus(bus), .bus_conflict(bus_conflict), .cf(cf), .zf(zf)
  );

  // Architectural model: plain integers, updated once per clock edge.
  int m_a, m_b, m_ir, m_mar, m_pc, m_out, m_ov, m_cf, m_zf;
  int m_ram [16];
  bit m_known [16];

  int n_total = 0;
  int n_bad = 0;
  bit chk_on = 0;
  logic [7:0] last_bus;
  logic       last_conf;

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    n_total++;
    if (act !== 8'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, 8'(exp));
    end
  endtask

  function automatic int m_sum(input logic [14:0] s);
    if (s[SUB]) return (m_a - m_b + 256) % 256;
    return (m_a + m_b) % 256;
  endfunction

  function automatic int m_carry(input logic [14:0] s);
    if (s[SUB]) return (m_a >= m_b) ? 1 : 0;
    return (m_a + m_b > 255) ? 1 : 0;
  endfunction

  function automatic int m_bus(input logic [14:0] s);
    if (s[RO])   return m_ram[m_mar];
    if (s[IO])   return m_ir % 16;
    if (s[AO])   return m_a;
    if (s[SUMO]) return m_sum(s);
    if (s[CO])   return m_pc;
    return 0;
  endfunction

  task automatic model_clear();
    m_a = 0; m_b = 0; m_ir = 0; m_mar = 0; m_pc = 0;
    m_out = 0; m_ov = 0; m_cf = 0; m_zf = 0;
  endtask

  task automatic model_step(input logic [14:0] s, input logic pm, input logic we,
                            input int pa, input int pd);
    int b, nsum, ncar;
    b    = m_bus(s);
    nsum = m_sum(s);
    ncar = m_carry(s);
    if (pm) begin
      if (we) begin
        m_ram[pa] = pd;
        m_known[pa] = 1;
      end
      m_ov = 0;
    end else if (s[HLT]) begin
      m_ov = 0;
    end else begin
      if (s[RI] && !s[RO]) begin
        m_ram[m_mar] = b;
        m_known[m_mar] = 1;
      end
      if (s[J])       m_pc = b % 16;
      else if (s[CE]) m_pc = (m_pc + 1) % 16;
      if (s[MI]) m_mar = b % 16;
      if (s[II]) m_ir = b;
      if (s[AI]) begin
        m_a = b;
        if (s[SUMO]) begin
          m_cf = ncar;
          m_zf = (nsum == 0) ? 1 : 0;
        end
      end
      if (s[BI]) m_b = b;
      if (s[OI]) m_out = b;
      m_ov = s[OI] ? 1 : 0;
    end
  endtask

  // Registered outputs against the model after every edge.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("pc", 8'(pc), m_pc);
      chk("insn", insn, m_ir);
      chk("out_val", out_val, m_out);
      chk("out_valid", 8'(out_valid), m_ov);
      chk("cf", 8'(cf), m_cf);
      chk("zf", 8'(zf), m_zf);
    end
  end

  // One clock cycle: strobes change on negedge, combinational outputs are
  // checked, the model advances, strobes drop after the edge.
  task automatic cyc_full(input logic [14:0] s, input logic pm, input logic we,
                          input int pa, input int pd);
    int nd;
    @(negedge clk);
    s_v = s; prog_mode = pm; prog_we = we;
    prog_addr = 4'(pa); prog_data = 8'(pd);
    #1;
    last_bus = bus;
    last_conf = bus_conflict;
    if (!(s[RO] && !m_known[m_mar])) chk("bus", bus, m_bus(s));
    nd = int'(s[RO]) + int'(s[IO]) + int'(s[AO]) + int'(s[SUMO]) + int'(s[CO]);
    chk("bus_conflict", 8'(bus_conflict), (nd > 1) ? 1 : 0);
    model_step(s, pm, we, pa, pd);
    @(posedge clk);
    #2;
    s_v = '0; prog_mode = 1'b0; prog_we = 1'b0;
  endtask

  task automatic cyc(input logic [14:0] s);
    cyc_full(s, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic prog(input int a, input int d);
    cyc_full('0, 1'b1, 1'b1, a, d);
  endtask

  task automatic set_mar(input int k);
    while (m_pc != k) cyc(15'(1 << CE));
    cyc(15'((1 << CO) | (1 << MI)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_v = '0;
    #3;
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_pc", 8'(pc), 0);
    chk("rst_insn", insn, 0);
    chk("rst_out_valid", 8'(out_valid), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_ram[i] = 0;
      m_known[i] = 0;
    end
    model_clear();
    #2;
    rst = 1'b0;
    chk_on = 1;
    repeat (2) @(negedge clk);
    chk("init_pc", 8'(pc), 0);
    chk("init_insn", insn, 0);
    chk("init_cf", 8'(cf), 0);
    chk("init_zf", 8'(zf), 0);
    chk("init_out_valid", 8'(out_valid), 0);
    rst = 1'b1;

    // Program RAM; strobes pulsed meanwhile must be ignored.
    prog(3, 8'h2A); prog(0, 8'h1E); prog(14, 8'h07); prog(5, 8'h05);
    prog(6, 8'h03); prog(7, 8'hF0); prog(8, 8'h20); prog(9, 8'h42);
    prog(15, 8'h09);
    cyc_full(15'((1 << AI) | (1 << CE)), 1'b1, 1'b0, 0, 0);
    chk("prog_pc_hold", 8'(pc), 0);
    cyc(15'(1 << AO));
    chk("prog_a_hold", last_bus, 8'h00);

    // RAM survives reset.
    do_reset();
    set_mar(3);
    cyc(15'(1 << RO));
    chk("ram3_after_rst", last_bus, 8'h2A);
    set_mar(14);
    cyc(15'(1 << RO));
    chk("ram14", last_bus, 8'h07);

    // LDA 14 from a clean reset.
    do_reset();
    cyc(15'((1 << CO) | (1 << MI)));
    cyc(15'((1 << RO) | (1 << II) | (1 << CE)));
    chk("lda_insn", insn, 8'h1E);
    chk("lda_pc", 8'(pc), 1);
    cyc(15'((1 << IO) | (1 << MI)));
    cyc(15'((1 << RO) | (1 << AI)));
    cyc(15'(1 << AO));
    chk("lda_a", last_bus, 8'h07);

    // F0 + 20: carry out, nonzero.
    set_mar(7); cyc(15'((1 << RO) | (1 << AI)));
    set_mar(8); cyc(15'((1 << RO) | (1 << BI)));
    cyc(15'((1 << SUMO) | (1 << AI)));
    chk("add_cf", 8'(cf), 1);
    chk("add_zf", 8'(zf), 0);
    cyc(15'(1 << AO));
    chk("add_a", last_bus, 8'h10);

    // 5 - 5: no borrow, zero.
    set_mar(5);
    cyc(15'((1 << RO) | (1 << AI)));
    cyc(15'((1 << RO) | (1 << BI)));
    cyc(15'((1 << SUB) | (1 << SUMO) | (1 << AI)));
    chk("sub0_cf", 8'(cf), 1);
    chk("sub0_zf", 8'(zf), 1);
    cyc(15'(1 << AO));
    chk("sub0_a", last_bus, 8'h00);

    // 3 - 5: borrow.
    set_mar(6); cyc(15'((1 << RO) | (1 << AI)));
    set_mar(5); cyc(15'((1 << RO) | (1 << BI)));
    cyc(15'((1 << SUB) | (1 << SUMO) | (1 << AI)));
    chk("subb_cf", 8'(cf), 0);
    chk("subb_zf", 8'(zf), 0);
    cyc(15'(1 << AO));
    chk("subb_a", last_bus, 8'hFE);

    // PC wrap.
    while (m_pc != 15) cyc(15'(1 << CE));
    cyc(15'(1 << CE));
    chk("pc_wrap", 8'(pc), 0);

    // Jump wins over ce.
    set_mar(15);
    cyc(15'((1 << RO) | (1 << II)));
    cyc(15'((1 << IO) | (1 << J) | (1 << CE)));
    chk("jump_pc", 8'(pc), 9);

    // Output register and its single-cycle pulse.
    set_mar(9);
    cyc(15'((1 << RO) | (1 << AI)));
    cyc(15'((1 << AO) | (1 << OI)));
    chk("out_val", out_val, 8'h42);
    chk("out_pulse_hi", 8'(out_valid), 1);
    cyc('0);
    chk("out_pulse_lo", 8'(out_valid), 0);

    // Conflict: RAM wins over A.
    cyc(15'((1 << SUMO) | (1 << AI)));
    cyc(15'((1 << RO) | (1 << AO)));
    chk("conf_bus", last_bus, 8'h42);
    chk("conf_flag", 8'(last_conf), 1);

    // Normal RAM write.
    set_mar(10);
    cyc(15'((1 << AO) | (1 << RI)));
    cyc(15'(1 << RO));
    chk("ri_write", last_bus, 8'h47);

    // Halt freezes everything.
    cyc(15'((1 << HLT) | (1 << AI) | (1 << CE) | (1 << RI) | (1 << CO)));
    chk("hlt_pc", 8'(pc), 10);
    cyc(15'(1 << RO));
    chk("hlt_ram", last_bus, 8'h47);
    cyc(15'(1 << AO));
    chk("hlt_a", last_bus, 8'h47);
    cyc(15'((1 << HLT) | (1 << AO) | (1 << OI)));
    chk("hlt_no_pulse", 8'(out_valid), 0);

    do_reset();
    chk("final_cf", 8'(cf), 0);
    chk("final_out", out_val, 0);
    cyc('0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
